// File: rtl/sample_seq_pkg.sv
// Shared types and constants for the ADC -> FIR -> DAC sample sequencer.
package sample_seq_pkg;

    localparam int unsigned ADC_W        = 12;
    localparam int unsigned FIR_IN_W     = 16;
    localparam int unsigned FIR_OUT_W    = 32;
    localparam int unsigned DAC_W        = 12;
    localparam int unsigned ERR_CNT_W    = 16;
    localparam int unsigned FIR_SLICE_HI = 27;
    localparam int unsigned FIR_SLICE_LO = 16;

    localparam logic [DAC_W-1:0] DAC_OFFSET = 12'h800;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONVERT   = 3'd1,
        WAIT_ADC  = 3'd2,
        FIR_SEND  = 3'd3,
        WAIT_FIR  = 3'd4,
        DAC_START = 3'd5,
        WAIT_DAC  = 3'd6
    } state_t;

    // Signed FIR slice to offset-binary DAC code, wrapping modulo 2^DAC_W.
    function automatic logic [DAC_W-1:0] fir_to_dac(input logic [DAC_W-1:0] slice);
        return slice + DAC_OFFSET;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period divider: one-cycle tick every SAMPLE_FACTOR enabled cycles.
module sample_tick_gen #(
    parameter int unsigned SAMPLE_FACTOR = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (SAMPLE_FACTOR > 1) ? $clog2(SAMPLE_FACTOR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_FACTOR - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/sample_sequencer.sv
// Per-sample sequencer: ADC convert -> FIR stream -> DAC write, with overrun/timeout counters.
// Optional FIR_BYPASS_EN adds a bypass input that routes ADC samples straight to the DAC.
module sample_sequencer
    import sample_seq_pkg::*;
#(
    parameter int unsigned SAMPLE_FACTOR = 10000,
    parameter int unsigned STAGE_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  adc_convst,
    input  logic                  adc_eoc,
    input  logic [ADC_W-1:0]      adc_data,
    output logic                  fir_s_tvalid,
    input  logic                  fir_s_tready,
    output logic [FIR_IN_W-1:0]   fir_s_tdata,
    input  logic                  fir_m_tvalid,
    input  logic [FIR_OUT_W-1:0]  fir_m_tdata,
    output logic                  dac_set,
    input  logic                  dac_busy,
`ifdef FIR_BYPASS_EN
    input  logic                  bypass,
`endif
    output logic [DAC_W-1:0]      dac_value,
    output logic [ERR_CNT_W-1:0]  overrun_cnt,
    output logic [ERR_CNT_W-1:0]  timeout_cnt,
    output logic                  active
);

    localparam int unsigned ST_W = $clog2(STAGE_TIMEOUT + 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STAGE_TIMEOUT - 1);
    localparam logic [ST_W-1:0] ST_MAX  = '1;
    localparam logic [ST_W-1:0] DAC_HOLD = ST_W'(2);

    state_t                 state_q, state_d;
    logic [ST_W-1:0]        stage_q, stage_d;
    logic                   convst_d, tvalid_d, set_d, active_d;
    logic [FIR_IN_W-1:0]    tdata_d;
    logic [DAC_W-1:0]       dac_d;
    logic [ERR_CNT_W-1:0]   overrun_d, timeout_d;
    logic                   tick;
    logic                   byp_sel;
    logic                   unused_fir_bits;

`ifdef FIR_BYPASS_EN
    assign byp_sel = bypass;
`else
    assign byp_sel = 1'b0;
`endif

    assign unused_fir_bits = ^{fir_m_tdata[FIR_OUT_W-1:FIR_SLICE_HI+1],
                               fir_m_tdata[FIR_SLICE_LO-1:0]};

    sample_tick_gen #(
        .SAMPLE_FACTOR(SAMPLE_FACTOR)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            stage_q      <= '0;
            adc_convst   <= 1'b0;
            fir_s_tvalid <= 1'b0;
            fir_s_tdata  <= '0;
            dac_set      <= 1'b0;
            dac_value    <= DAC_OFFSET;
            overrun_cnt  <= '0;
            timeout_cnt  <= '0;
            active       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            adc_convst   <= convst_d;
            fir_s_tvalid <= tvalid_d;
            fir_s_tdata  <= tdata_d;
            dac_set      <= set_d;
            dac_value    <= dac_d;
            overrun_cnt  <= overrun_d;
            timeout_cnt  <= timeout_d;
            active       <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        convst_d  = 1'b0;
        tvalid_d  = fir_s_tvalid;
        tdata_d   = fir_s_tdata;
        set_d     = 1'b0;
        dac_d     = dac_value;
        overrun_d = overrun_cnt;
        timeout_d = timeout_cnt;
        stage_d   = (stage_q == ST_MAX) ? stage_q : stage_q + ST_W'(1);
        active_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d  = CONVERT;
                    convst_d = 1'b1;
                end
            end
            CONVERT: state_d = WAIT_ADC;
            WAIT_ADC: begin
                if (adc_eoc) begin
                    tdata_d = {{(FIR_IN_W - ADC_W){1'b0}}, adc_data};
                    if (byp_sel) begin
                        dac_d   = adc_data;
                        state_d = DAC_START;
                    end else begin
                        tvalid_d = 1'b1;
                        state_d  = FIR_SEND;
                    end
                end
            end
            FIR_SEND: begin
                if (fir_s_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = WAIT_FIR;
                end
            end
            WAIT_FIR: begin
                if (fir_m_tvalid) begin
                    dac_d   = fir_to_dac(fir_m_tdata[FIR_SLICE_HI:FIR_SLICE_LO]);
                    state_d = DAC_START;
                end
            end
            DAC_START: begin
                if (!dac_busy) begin
                    set_d   = 1'b1;
                    state_d = WAIT_DAC;
                end
            end
            WAIT_DAC: begin
                // stage_q counts from the dac_set cycle, so >= 2 enforces the settle gap
                if (!dac_busy && stage_q >= DAC_HOLD) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q inside {WAIT_ADC, FIR_SEND, WAIT_FIR, WAIT_DAC}) &&
            (state_d == state_q) && (stage_q == ST_LAST)) begin
            state_d   = IDLE;
            tvalid_d  = 1'b0;
            timeout_d = sat_inc(timeout_cnt);
        end

        if (tick && (state_q != IDLE)) begin
            overrun_d = sat_inc(overrun_cnt);
        end

        if (state_d != state_q) begin
            stage_d = '0;
        end

        active_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// Randomized and directed bench for sample_sequencer against a cycle-level behavioural model.
module tb_sample_sequencer;

    localparam int SF = 16;
    localparam int TO = 40;

    localparam int P_IDLE = 0, P_CONV = 1, P_WADC = 2, P_FSEND = 3,
                   P_WFIR = 4, P_DSTART = 5, P_WDAC = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        adc_eoc = 1'b0;
    logic [11:0] adc_data = '0;
    logic        fir_s_tready = 1'b0;
    logic        fir_m_tvalid = 1'b0;
    logic [31:0] fir_m_tdata = '0;
    logic        dac_busy = 1'b0;
`ifdef FIR_BYPASS_EN
    logic        bypass = 1'b0;
`endif

    logic        adc_convst, fir_s_tvalid, dac_set, active;
    logic [15:0] fir_s_tdata, overrun_cnt, timeout_cnt;
    logic [11:0] dac_value;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: sequence position, cycles spent there, enabled-run length and expected outputs.
    int          m_phase = P_IDLE;
    int          m_age = 0;
    int          m_run = 0;
    bit          m_tick = 1'b0;
    bit          m_convst = 1'b0, m_set = 1'b0, m_tvalid = 1'b0;
    logic [15:0] m_tdata = '0;
    logic [11:0] m_dacv = 12'h800;
    int          m_ovr = 0, m_to = 0;

    always #5 clk = ~clk;

    sample_sequencer #(
        .SAMPLE_FACTOR(SF),
        .STAGE_TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .adc_convst   (adc_convst),
        .adc_eoc      (adc_eoc),
        .adc_data     (adc_data),
        .fir_s_tvalid (fir_s_tvalid),
        .fir_s_tready (fir_s_tready),
        .fir_s_tdata  (fir_s_tdata),
        .fir_m_tvalid (fir_m_tvalid),
        .fir_m_tdata  (fir_m_tdata),
        .dac_set      (dac_set),
        .dac_busy     (dac_busy),
`ifdef FIR_BYPASS_EN
        .bypass       (bypass),
`endif
        .dac_value    (dac_value),
        .overrun_cnt  (overrun_cnt),
        .timeout_cnt  (timeout_cnt),
        .active       (active)
    );

    function automatic bit byp_in();
`ifdef FIR_BYPASS_EN
        return bypass;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented to that edge.
    task automatic model_step();
        int np;
        bit tick_seen;
        tick_seen = m_tick;
        m_convst  = 1'b0;
        m_set     = 1'b0;
        if (rst) begin
            m_phase = P_IDLE; m_age = 0; m_run = 0; m_tick = 1'b0;
            m_tvalid = 1'b0; m_dacv = 12'h800; m_ovr = 0; m_to = 0;
            return;
        end
        m_run  = enable ? m_run + 1 : 0;
        m_tick = enable && (m_run % SF == 0);
        np = m_phase;
        case (m_phase)
            P_IDLE:   if (tick_seen) begin np = P_CONV; m_convst = 1'b1; end
            P_CONV:   np = P_WADC;
            P_WADC:   if (adc_eoc) begin
                          m_tdata = {4'h0, adc_data};
                          if (byp_in()) begin m_dacv = adc_data; np = P_DSTART; end
                          else begin m_tvalid = 1'b1; np = P_FSEND; end
                      end
            P_FSEND:  if (fir_s_tready) begin m_tvalid = 1'b0; np = P_WFIR; end
            P_WFIR:   if (fir_m_tvalid) begin
                          m_dacv = 12'((fir_m_tdata >> 16) + 32'h800);
                          np = P_DSTART;
                      end
            P_DSTART: if (!dac_busy) begin m_set = 1'b1; np = P_WDAC; end
            P_WDAC:   if (!dac_busy && m_age >= 2) np = P_IDLE;
            default:  np = P_IDLE;
        endcase
        if ((m_phase inside {P_WADC, P_FSEND, P_WFIR, P_WDAC}) && np == m_phase && m_age + 1 >= TO) begin
            np = P_IDLE;
            m_tvalid = 1'b0;
            if (m_to < 65535) m_to++;
        end
        if (tick_seen && m_phase != P_IDLE && m_ovr < 65535) m_ovr++;
        m_age   = (np == m_phase) ? m_age + 1 : 0;
        m_phase = np;
    endtask

    // One clock: step the model, then compare every DUT output on the falling edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        model_step();
        chk("adc_convst", 32'(adc_convst), 32'(m_convst));
        chk("dac_set", 32'(dac_set), 32'(m_set));
        chk("fir_s_tvalid", 32'(fir_s_tvalid), 32'(m_tvalid));
        if (m_tvalid) chk("fir_s_tdata", 32'(fir_s_tdata), 32'(m_tdata));
        chk("dac_value", 32'(dac_value), 32'(m_dacv));
        chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
        chk("timeout_cnt", 32'(timeout_cnt), 32'(m_to));
        chk("active", 32'(active), 32'(m_phase != P_IDLE));
    endtask

    task automatic run_seq(input logic [11:0] d, input logic [31:0] md, input bit byp,
                           input bit stop_in_wdac, input logic [11:0] exp_dac);
        int n;
        bit saw_tv;
        n = 0;
        while (!adc_convst && n < 80) begin cycle(); n++; end
        chk("convst_seen", 32'(adc_convst), 32'd1);
        cycle();
`ifdef FIR_BYPASS_EN
        bypass = byp;
`endif
        adc_eoc = 1'b1; adc_data = d;
        cycle();
        adc_eoc = 1'b0; adc_data = 12'($urandom);
        fir_s_tready = 1'b1; fir_m_tvalid = 1'b1; fir_m_tdata = md; dac_busy = 1'b0;
        saw_tv = 1'b0;
        n = 0;
        while (!dac_set && n < 10) begin saw_tv |= fir_s_tvalid; cycle(); n++; end
        chk("dac_set_seen", 32'(dac_set), 32'd1);
        chk("dac_value_at_set", 32'(dac_value), 32'(exp_dac));
        if (byp) chk("bypass_no_tvalid", 32'(saw_tv), 32'd0);
        fir_m_tvalid = 1'b0; fir_s_tready = 1'b0;
`ifdef FIR_BYPASS_EN
        bypass = 1'b0;
`endif
        dac_busy = 1'b1;
        cycle(); cycle();
        if (!stop_in_wdac) begin
            dac_busy = 1'b0;
            n = 0;
            while (active && n < 10) begin cycle(); n++; end
            chk("seq_done", 32'(active), 32'd0);
        end
    endtask

    initial begin
        int n;
        // Reset state and tick cadence from reset release.
        rst = 1'b1; enable = 1'b1;
        repeat (3) cycle();
        chk("rst_dac_value", 32'(dac_value), 32'h800);
        chk("rst_active", 32'(active), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            cycle();
            chk("convst_timing", 32'(adc_convst), 32'(i == 17));
        end
        cycle();
        // FIR handshake held for three not-ready cycles.
        adc_eoc = 1'b1; adc_data = 12'h123;
        cycle();
        adc_eoc = 1'b0; adc_data = 12'hFFF;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (fir_s_tvalid) begin
                n++;
                chk("tdata_stable", 32'(fir_s_tdata), 32'h0123);
            end
            fir_s_tready = (i == 3);
            cycle();
        end
        fir_s_tready = 1'b0;
        chk("tvalid_len", 32'(n), 32'd4);
        fir_m_tvalid = 1'b1; fir_m_tdata = 32'h0FFF_0000;
        cycle();
        fir_m_tvalid = 1'b0;
        chk("dac_7ff", 32'(dac_value), 32'h7FF);
        dac_busy = 1'b0;
        cycle();
        chk("dac_set_pulse", 32'(dac_set), 32'd1);
        dac_busy = 1'b1;
        cycle(); cycle();
        dac_busy = 1'b0;
        cycle();
        chk("back_idle", 32'(active), 32'd0);
        run_seq(12'h0AB, 32'h0801_0000, 1'b0, 1'b0, 12'h001);

        // ADC never answers: one timeout, two dropped ticks, then a clean sequence.
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        n = 0;
        while (!adc_convst && n < 40) begin cycle(); n++; end
        n = 0;
        while (active && n < 100) begin cycle(); n++; end
        chk("to_overrun", 32'(overrun_cnt), 32'd2);
        chk("to_timeout", 32'(timeout_cnt), 32'd1);
        chk("to_idle", 32'(active), 32'd0);
        run_seq(12'h456, 32'h0123_0000, 1'b0, 1'b0, 12'h923);
        chk("to_overrun_after", 32'(overrun_cnt), 32'd2);

        // Reset while waiting on the DAC.
        run_seq(12'h111, 32'h0BAB_0000, 1'b0, 1'b1, 12'h3AB);
        rst = 1'b1;
        cycle();
        chk("wdac_rst_dac", 32'(dac_value), 32'h800);
        chk("wdac_rst_ovr", 32'(overrun_cnt), 32'd0);
        chk("wdac_rst_to", 32'(timeout_cnt), 32'd0);
        chk("wdac_rst_active", 32'(active), 32'd0);
        rst = 1'b0; dac_busy = 1'b0;

`ifdef FIR_BYPASS_EN
        run_seq(12'h5A5, 32'hFFFF_FFFF, 1'b1, 1'b0, 12'h5A5);
`endif

        // Random traffic, including enable drops and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            adc_eoc      = ($urandom_range(0, 5) == 0);
            adc_data     = 12'($urandom);
            fir_s_tready = ($urandom_range(0, 1) == 0);
            fir_m_tvalid = ($urandom_range(0, 4) == 0);
            fir_m_tdata  = $urandom;
            dac_busy     = ($urandom_range(0, 2) == 0);
`ifdef FIR_BYPASS_EN
            bypass       = ($urandom_range(0, 3) == 0);
`endif
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
